// File: rtl/proc_pkg.sv
// Shared processor constants: datapath widths, register-bank geometry and ALU opcodes.
// Used by the operand stage and the ALU.
package proc_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int ADDR_W = 3;
  localparam int IMM_W  = 6;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/reg_bank.sv
// Architectural register bank: one write port, two write-before-read read ports.
// R0 is hard zero; addresses beyond NREGS read zero and ignore writes.
module reg_bank
  import proc_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] bank [NREGS];

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return int'(addr) < NREGS;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) bank[i] <= '0;
    end else if (we && waddr != '0 && in_range(waddr)) begin
      bank[waddr] <= wdata;
    end
  end

  // Same-cycle write is forwarded so the operand register sees the new value.
  always_comb begin
    rdata_a = '0;
    if (raddr_a != '0 && in_range(raddr_a)) begin
      if (we && waddr == raddr_a) rdata_a = wdata;
      else                        rdata_a = bank[raddr_a];
    end
  end

  always_comb begin
    rdata_b = '0;
    if (raddr_b != '0 && in_range(raddr_b)) begin
      if (we && waddr == raddr_b) rdata_b = wdata;
      else                        rdata_b = bank[raddr_b];
    end
  end

endmodule

// File: rtl/regfile_operand_stage.sv
// Register-read / operand stage ahead of the ALU: bank read, immediate extension,
// operand select and the stall/flush operand register (one-cycle latency).
module regfile_operand_stage
  import proc_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              validIn,
  input  logic [ADDR_W-1:0] rsAddr,
  input  logic [ADDR_W-1:0] rtAddr,
  input  logic [IMM_W-1:0]  imm,
  input  logic              aluSrc,
  input  logic [2:0]        aluCtrlIn,
  input  logic              stall,
  input  logic              flush,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] input1,
  output logic [DATA_W-1:0] input2,
  output logic [2:0]        ALUControl,
  output logic [DATA_W-1:0] storeData,
  output logic              validOut
);

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] op_b;

  reg_bank u_bank (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (regWrite),
    .waddr   (writeAddr),
    .wdata   (writeData),
    .raddr_a (rsAddr),
    .raddr_b (rtAddr),
    .rdata_a (rs_val),
    .rdata_b (rt_val)
  );

  assign op_b = aluSrc ? sext_imm(imm) : rt_val;

  // Flush outranks stall; a stalled stage never re-reads the bank.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      input1     <= '0;
      input2     <= '0;
      storeData  <= '0;
      ALUControl <= ALU_AND;
      validOut   <= 1'b0;
    end else if (flush) begin
      input1     <= '0;
      input2     <= '0;
      storeData  <= '0;
      ALUControl <= ALU_AND;
      validOut   <= 1'b0;
    end else if (!stall) begin
      input1     <= rs_val;
      input2     <= op_b;
      storeData  <= rt_val;
      ALUControl <= aluCtrlIn;
      validOut   <= validIn;
    end
  end

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Directed and randomized bench for regfile_operand_stage against an array-based
// reference model of the register bank and operand register.
module tb_regfile_operand_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        validIn;
  logic [2:0]  rsAddr, rtAddr;
  logic [5:0]  imm;
  logic        aluSrc;
  logic [2:0]  aluCtrlIn;
  logic        stall, flush;
  logic        regWrite;
  logic [2:0]  writeAddr;
  logic [15:0] writeData;
  logic [15:0] input1, input2, storeData;
  logic [2:0]  ALUControl;
  logic        validOut;

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_bank [8];
  logic [15:0] e_in1, e_in2, e_store;
  logic [2:0]  e_ctrl;
  logic        e_valid;

  regfile_operand_stage dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .validIn    (validIn),
    .rsAddr     (rsAddr),
    .rtAddr     (rtAddr),
    .imm        (imm),
    .aluSrc     (aluSrc),
    .aluCtrlIn  (aluCtrlIn),
    .stall      (stall),
    .flush      (flush),
    .regWrite   (regWrite),
    .writeAddr  (writeAddr),
    .writeData  (writeData),
    .input1     (input1),
    .input2     (input2),
    .ALUControl (ALUControl),
    .storeData  (storeData),
    .validOut   (validOut)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".input1"}, input1, e_in1);
    chk({tag, ".input2"}, input2, e_in2);
    chk({tag, ".storeData"}, storeData, e_store);
    chk({tag, ".ALUControl"}, {13'd0, ALUControl}, {13'd0, e_ctrl});
    chk({tag, ".validOut"}, {15'd0, validOut}, {15'd0, e_valid});
  endtask

  function automatic logic [15:0] ref_rd(input logic [2:0] a);
    if (a == 0) return 16'h0000;
    if (regWrite && writeAddr == a) return writeData;
    return ref_bank[a];
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 8; i++) ref_bank[i] = 16'h0000;
    e_in1 = 0; e_in2 = 0; e_store = 0; e_ctrl = 0; e_valid = 0;
  endtask

  task automatic idle();
    validIn = 0; rsAddr = 0; rtAddr = 0; imm = 0; aluSrc = 0; aluCtrlIn = 0;
    stall = 0; flush = 0; regWrite = 0; writeAddr = 0; writeData = 0;
  endtask

  // Predict the edge from current inputs, advance one clock, compare 1 time unit later.
  task automatic step(input string tag);
    logic [15:0] rs_v, rt_v;
    rs_v = ref_rd(rsAddr);
    rt_v = ref_rd(rtAddr);
    if (flush) begin
      e_in1 = 0; e_in2 = 0; e_store = 0; e_ctrl = 3'b000; e_valid = 0;
    end else if (!stall) begin
      e_in1   = rs_v;
      e_in2   = aluSrc ? {{10{imm[5]}}, imm} : rt_v;
      e_store = rt_v;
      e_ctrl  = aluCtrlIn;
      e_valid = validIn;
    end
    if (regWrite && writeAddr != 0) ref_bank[writeAddr] = writeData;
    @(posedge clock);
    #1;
    chk_all(tag);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    idle();
    regWrite = 1; writeAddr = a; writeData = d;
    step("write");
  endtask

  initial begin
    idle();
    ref_reset();
    reset_n = 0;
    #22;
    chk_all("reset");
    reset_n = 1;
    @(posedge clock); #1;
    chk_all("post_release");

    // T1 write then read
    wr(3'd3, 16'h1234);
    idle(); rsAddr = 3; rtAddr = 0; validIn = 1; aluCtrlIn = 3'b001;
    step("t1");
    chk("t1.const_in1", input1, 16'h1234);
    chk("t1.const_in2", input2, 16'h0000);

    // T2 R0 protection
    wr(3'd0, 16'hFFFF);
    idle(); rsAddr = 0; rtAddr = 0; validIn = 1;
    step("t2");
    chk("t2.const_in1", input1, 16'h0000);

    // T3 bypass
    idle(); regWrite = 1; writeAddr = 5; writeData = 16'hBEEF;
    rsAddr = 5; rtAddr = 5; validIn = 1;
    step("t3");
    chk("t3.const_store", storeData, 16'hBEEF);

    // T4 immediates
    idle(); aluSrc = 1; imm = 6'b111110; aluCtrlIn = 3'b010; rtAddr = 3; validIn = 1;
    step("t4a");
    chk("t4a.const_in2", input2, 16'hFFFE);
    imm = 6'b011111;
    step("t4b");
    chk("t4b.const_in2", input2, 16'h001F);

    // T5 stall then stall+flush
    wr(3'd4, 16'h00AA);
    idle(); rsAddr = 4; validIn = 1; aluCtrlIn = 3'b110;
    step("t5.load");
    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1; rsAddr = 3'(i + 1); validIn = 1;
      regWrite = 1; writeAddr = 4; writeData = 16'h5500 + 16'(i);
      step("t5.stall");
      chk("t5.const_hold", input1, 16'h00AA);
    end
    idle(); stall = 1; flush = 1; rsAddr = 4; validIn = 1; aluCtrlIn = 3'b111;
    step("t5.flush");

    // T6 async reset mid-cycle
    wr(3'd2, 16'h7777);
    idle(); rsAddr = 2; validIn = 1; aluCtrlIn = 3'b010;
    step("t6.load");
    #2;
    reset_n = 0;
    #1;
    ref_reset();
    chk_all("t6.async");
    #3;
    reset_n = 1;
    idle(); rsAddr = 2; validIn = 1;
    step("t6.after");

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      validIn   = 1'($urandom);
      rsAddr    = 3'($urandom);
      rtAddr    = 3'($urandom);
      imm       = 6'($urandom);
      aluSrc    = 1'($urandom);
      aluCtrlIn = 3'($urandom);
      stall     = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      regWrite  = 1'($urandom);
      writeAddr = ($urandom_range(0, 3) == 0) ? rsAddr : 3'($urandom);
      writeData = 16'($urandom);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
